// File: rtl/text_rasterizer_pkg.sv
// rtl/text_rasterizer_pkg.sv - shared types and constants for the text rasterizer
// Purpose: FSM state encoding, character attribute classes, Apple II row map strides.
// Ports: none (package).
package text_raster_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_T,
        FETCH_G,
        LOAD,
        EMIT,
        NEXT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        CC_INVERSE,
        CC_FLASH,
        CC_NORMAL
    } char_class_t;

    // Apple II text page: rows 0..7 are 128 bytes apart, each group of 8 rows
    // is offset by another 40 bytes inside the same 128-byte stripe.
    localparam int unsigned APPLE_ROW_STRIDE   = 128;
    localparam int unsigned APPLE_GROUP_STRIDE = 40;

    // Attribute lives in the top two bits of the character code.
    function automatic char_class_t classify(input logic [7:0] code);
        case (code[7:6])
            2'b00:   return CC_INVERSE;
            2'b01:   return CC_FLASH;
            default: return CC_NORMAL;
        endcase
    endfunction

endpackage

// File: rtl/text_row_base.sv
// rtl/text_row_base.sv - text row to text RAM base address
// Purpose: combinational map from text row index to the address of column 0.
// Ports:
//   row   in   RW   text row index
//   base  out  16   text RAM address of the row's first character
module text_row_base
    import text_raster_pkg::*;
#(
    parameter int          COLS       = 40,
    parameter logic [15:0] TXT_BASE   = 16'h400,
    parameter int          INTERLEAVE = 1,
    parameter int          RW         = 5
) (
    input  logic [RW-1:0] row,
    output logic [15:0]   base
);

    // Arithmetic is done at 32 bits and truncated, so oversized maps simply wrap.
    always_comb begin
        if (INTERLEAVE != 0) begin
            base = 16'(32'(TXT_BASE)
                      + (32'(row) % 32'd8) * APPLE_ROW_STRIDE
                      + (32'(row) / 32'd8) * APPLE_GROUP_STRIDE);
        end else begin
            base = 16'(32'(TXT_BASE) + 32'(row) * 32'(COLS));
        end
    end

endmodule

// File: rtl/text_rasterizer.sv
// rtl/text_rasterizer.sv - text page to framebuffer pixel renderer
// Purpose: walks the text page row/slice/column, fetches character code and
//   glyph slice, and emits one pixel per valid/ready handshake with inverse
//   and flash attributes.
// Ports:
//   clk, res            clock, synchronous active-high reset
//   start/busy/done     frame start pulse, frame in progress, 1-cycle completion
//   txt_adr/txt_q       text RAM read port (1-cycle latency)
//   crom_adr/crom_q     character ROM read port {char, slice} (1-cycle latency)
//   pix_valid/pix_ready pixel stream handshake
//   pix_d/pix_adr       pixel colour and linear framebuffer index
module text_rasterizer
    import text_raster_pkg::*;
#(
    parameter int               COLS         = 40,
    parameter int               ROWS         = 24,
    parameter int               GLYPH_W      = 7,
    parameter int               GLYPH_H      = 8,
    parameter int               PIX_W        = 24,
    parameter logic [15:0]      TXT_BASE     = 16'h400,
    parameter int               INTERLEAVE   = 1,
    parameter logic [PIX_W-1:0] FG           = 24'hffffff,
    parameter logic [PIX_W-1:0] BG           = 24'h000000,
    parameter int               FLASH_FRAMES = 16
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  txt_adr,
    input  logic [7:0]                   txt_q,
    output logic [7+$clog2(GLYPH_H):0]   crom_adr,
    input  logic [7:0]                   crom_q,
    output logic                         pix_valid,
    input  logic                         pix_ready,
    output logic [PIX_W-1:0]             pix_d,
    output logic [15:0]                  pix_adr
);

    localparam int C_W  = (COLS > 1)         ? $clog2(COLS)         : 1;
    localparam int R_W  = (ROWS > 1)         ? $clog2(ROWS)         : 1;
    localparam int PX_W = (GLYPH_W > 1)      ? $clog2(GLYPH_W)      : 1;
    localparam int GY_W = (GLYPH_H > 1)      ? $clog2(GLYPH_H)      : 1;
    localparam int F_W  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [C_W-1:0]  C_LAST  = C_W'(COLS - 1);
    localparam logic [R_W-1:0]  R_LAST  = R_W'(ROWS - 1);
    localparam logic [PX_W-1:0] PX_LAST = PX_W'(GLYPH_W - 1);
    localparam logic [GY_W-1:0] GY_LAST = GY_W'(GLYPH_H - 1);
    localparam logic [F_W-1:0]  F_LAST  = F_W'(FLASH_FRAMES - 1);

    state_t             state_q, state_d;
    logic [C_W-1:0]     c_q, c_d;
    logic [GY_W-1:0]    gy_q, gy_d;
    logic [R_W-1:0]     r_q, r_d;
    logic [PX_W-1:0]    px_q, px_d;
    logic [7:0]         char_q, char_d;
    char_class_t        cls_q, cls_d;
    logic [7:0]         shift_q, shift_d;
    logic               pix_valid_q, pix_valid_d;
    logic [PIX_W-1:0]   pix_d_q, pix_d_d;
    logic [15:0]        pix_adr_q, pix_adr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [F_W-1:0]     flash_cnt_q, flash_cnt_d;
    logic               flash_phase_q, flash_phase_d;

    logic [15:0]        row_base;
    logic [7:0]         crom_aligned;
    logic               invert;
    logic               pix_fire;
    logic               last_char;

    text_row_base #(
        .COLS       (COLS),
        .TXT_BASE   (TXT_BASE),
        .INTERLEAVE (INTERLEAVE),
        .RW         (R_W)
    ) u_row_base (
        .row  (r_q),
        .base (row_base)
    );

    // Slice bits moved so the leftmost pixel sits in bit 7; the shift register
    // then always emits from its MSB regardless of GLYPH_W.
    assign crom_aligned = 8'(crom_q << (8 - GLYPH_W));

    assign invert    = (cls_q == CC_INVERSE) || ((cls_q == CC_FLASH) && flash_phase_q);
    assign pix_fire  = pix_valid_q && pix_ready;
    assign last_char = (c_q == C_LAST) && (gy_q == GY_LAST) && (r_q == R_LAST);

    assign txt_adr   = row_base + 16'(c_q);
    // During FETCH_G the code comes straight from the RAM so the ROM read
    // overlaps the class latch; afterwards the latched code keeps it stable.
    assign crom_adr  = {(state_q == FETCH_G) ? txt_q : char_q, gy_q};

    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_valid = pix_valid_q;
    assign pix_d     = pix_d_q;
    assign pix_adr   = pix_adr_q;

    always_comb begin
        state_d       = state_q;
        c_d           = c_q;
        gy_d          = gy_q;
        r_d           = r_q;
        px_d          = px_q;
        char_d        = char_q;
        cls_d         = cls_q;
        shift_d       = shift_q;
        pix_valid_d   = pix_valid_q;
        pix_d_d       = pix_d_q;
        pix_adr_d     = pix_adr_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        flash_cnt_d   = flash_cnt_q;
        flash_phase_d = flash_phase_q;

        case (state_q)
            // DONE behaves like IDLE so a start in the done cycle chains frames.
            IDLE, DONE: begin
                if (start) begin
                    state_d   = FETCH_T;
                    busy_d    = 1'b1;
                    c_d       = '0;
                    gy_d      = '0;
                    r_d       = '0;
                    pix_adr_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH_T: begin
                state_d = FETCH_G;
            end
            FETCH_G: begin
                char_d  = txt_q;
                cls_d   = classify(txt_q);
                state_d = LOAD;
            end
            LOAD: begin
                pix_d_d     = (crom_aligned[7] ^ invert) ? FG : BG;
                shift_d     = crom_aligned << 1;
                px_d        = '0;
                pix_valid_d = 1'b1;
                state_d     = EMIT;
            end
            EMIT: begin
                if (pix_fire) begin
                    pix_adr_d = pix_adr_q + 16'd1;
                    if (px_q == PX_LAST) begin
                        pix_valid_d = 1'b0;
                        if (last_char) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            if (flash_cnt_q == F_LAST) begin
                                flash_cnt_d   = '0;
                                flash_phase_d = ~flash_phase_q;
                            end else begin
                                flash_cnt_d = flash_cnt_q + F_W'(1);
                            end
                        end else begin
                            state_d = NEXT;
                        end
                    end else begin
                        px_d    = px_q + PX_W'(1);
                        pix_d_d = (shift_q[7] ^ invert) ? FG : BG;
                        shift_d = shift_q << 1;
                    end
                end
            end
            NEXT: begin
                // Column is innermost, then glyph slice, then text row.
                if (c_q == C_LAST) begin
                    c_d = '0;
                    if (gy_q == GY_LAST) begin
                        gy_d = '0;
                        r_d  = r_q + R_W'(1);
                    end else begin
                        gy_d = gy_q + GY_W'(1);
                    end
                end else begin
                    c_d = c_q + C_W'(1);
                end
                state_d = FETCH_T;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q       <= IDLE;
            c_q           <= '0;
            gy_q          <= '0;
            r_q           <= '0;
            px_q          <= '0;
            char_q        <= '0;
            cls_q         <= CC_NORMAL;
            shift_q       <= '0;
            pix_valid_q   <= 1'b0;
            pix_d_q       <= BG;
            pix_adr_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            c_q           <= c_d;
            gy_q          <= gy_d;
            r_q           <= r_d;
            px_q          <= px_d;
            char_q        <= char_d;
            cls_q         <= cls_d;
            shift_q       <= shift_d;
            pix_valid_q   <= pix_valid_d;
            pix_d_q       <= pix_d_d;
            pix_adr_q     <= pix_adr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            flash_cnt_q   <= flash_cnt_d;
            flash_phase_q <= flash_phase_d;
        end
    end

endmodule

// File: tb/tb_text_rasterizer.sv
// tb/tb_text_rasterizer.sv - self-checking bench for text_rasterizer
module tb_text_rasterizer;

    localparam logic [23:0] FGC  = 24'h12ab34;
    localparam logic [23:0] BGC  = 24'h00c0de;
    localparam int          TOT0 = 5 * 10 * 7 * 4;
    localparam int          TOT1 = 3 * 3 * 5 * 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res, start, start1, pix_ready, ready1;
    logic        busy, done, pix_valid, busy1, done1, valid1;
    logic [15:0] txt_adr, pix_adr, txt_adr1, pix_adr1;
    logic [7:0]  txt_q, crom_q, txt_q1, crom_q1;
    logic [9:0]  crom_adr;
    logic [8:0]  crom_adr1;
    logic [23:0] pix_d, pix_d1;

    logic [7:0]  txt0 [0:65535];
    logic [7:0]  txt1 [0:65535];
    logic [7:0]  rom0 [0:1023];
    logic [7:0]  rom1 [0:511];

    int          vectors = 0;
    int          miscompares = 0;
    int          frames_done = 0;
    logic [23:0] first7 [$];

    text_rasterizer #(
        .COLS(5), .ROWS(10), .GLYPH_W(7), .GLYPH_H(4), .PIX_W(24),
        .TXT_BASE(16'h400), .INTERLEAVE(1), .FG(FGC), .BG(BGC), .FLASH_FRAMES(2)
    ) u_dut (
        .clk(clk), .res(res), .start(start), .busy(busy), .done(done),
        .txt_adr(txt_adr), .txt_q(txt_q), .crom_adr(crom_adr), .crom_q(crom_q),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_d(pix_d), .pix_adr(pix_adr)
    );

    text_rasterizer #(
        .COLS(3), .ROWS(3), .GLYPH_W(5), .GLYPH_H(2), .PIX_W(24),
        .TXT_BASE(16'h400), .INTERLEAVE(0), .FG(FGC), .BG(BGC), .FLASH_FRAMES(16)
    ) u_lin (
        .clk(clk), .res(res), .start(start1), .busy(busy1), .done(done1),
        .txt_adr(txt_adr1), .txt_q(txt_q1), .crom_adr(crom_adr1), .crom_q(crom_q1),
        .pix_valid(valid1), .pix_ready(ready1), .pix_d(pix_d1), .pix_adr(pix_adr1)
    );

    always @(posedge clk) begin
        txt_q   <= txt0[txt_adr];
        crom_q  <= rom0[crom_adr];
        txt_q1  <= txt1[txt_adr1];
        crom_q1 <= rom1[crom_adr1];
    end

    // Reference: pixel index -> (text row, column) -> RAM address.
    function automatic logic [15:0] m_adr(input int p, input int cols, input int w,
                                          input int h, input bit il);
        int y = p / (cols * w);
        int x = p % (cols * w);
        int r = y / h;
        int c = x / w;
        int base = il ? ('h400 + (r % 8) * 128 + (r / 8) * 40) : ('h400 + r * cols);
        return 16'(base + c);
    endfunction

    function automatic logic [23:0] m_pix(input bit inst, input int p, input bit phase);
        int cols = inst ? 3 : 5;
        int w    = inst ? 5 : 7;
        int h    = inst ? 2 : 4;
        int y    = p / (cols * w);
        int x    = p % (cols * w);
        logic [15:0] a    = m_adr(p, cols, w, h, !inst);
        logic [7:0]  code = inst ? txt1[a] : txt0[a];
        int          ri   = int'(code) * h + y % h;
        logic [7:0]  sl   = inst ? rom1[ri] : rom0[ri];
        bit          b    = sl[w - 1 - x % w];
        bit          inv  = (code[7:6] == 2'b00) || (code[7:6] == 2'b01 && phase);
        return (b ^ inv) ? FGC : BGC;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame on the main instance. Starts at #1 after an edge.
    task automatic run_frame(input int ready_pct, input int abort_at,
                             input bit chain, input bit already_started);
        int          idx = 0;
        int          cyc = 0;
        bit          phase = ((frames_done / 2) % 2) == 1;
        bit          stalled = 0;
        bit          accept;
        bit          rdy;
        logic [23:0] held_d;
        logic [15:0] held_a;
        if (!already_started) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("busy_after_start", 32'(busy), 32'd1);
        while (idx < TOT0 && cyc < 20 * TOT0) begin
            if (stalled) begin
                chk("stall_valid", 32'(pix_valid), 32'd1);
                chk("stall_pix_d", 32'(pix_d), 32'(held_d));
                chk("stall_pix_adr", 32'(pix_adr), 32'(held_a));
            end
            chk("done_low", 32'(done), 32'd0);
            chk("busy_high", 32'(busy), 32'd1);
            if (pix_valid) begin
                chk("pix_adr", 32'(pix_adr), 32'(idx));
                chk("pix_d", 32'(pix_d), 32'(m_pix(1'b0, idx, phase)));
                chk("txt_adr", 32'(txt_adr), 32'(m_adr(idx, 5, 7, 4, 1'b1)));
                if (abort_at >= 0 && idx == abort_at) begin
                    res = 1'b1; start = 1'b0; pix_ready = 1'b0;
                    @(posedge clk); #1;
                    chk("abort_valid", 32'(pix_valid), 32'd0);
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_done", 32'(done), 32'd0);
                    chk("abort_txt_adr", 32'(txt_adr), 32'h400);
                    res = 1'b0;
                    frames_done = 0;
                    return;
                end
            end
            rdy       = ($urandom_range(99) < ready_pct);
            pix_ready = rdy;
            start     = ($urandom_range(15) == 0);
            accept    = pix_valid && rdy;
            stalled   = pix_valid && !rdy;
            held_d    = pix_d;
            held_a    = pix_adr;
            if (accept && idx < 7 && first7.size() < 7) first7.push_back(pix_d);
            @(posedge clk); #1;
            cyc++;
            if (accept) idx++;
        end
        if (idx < TOT0) chk("frame_timeout", 32'(idx), 32'(TOT0));
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_fall", 32'(busy), 32'd0);
        chk("valid_after_done", 32'(pix_valid), 32'd0);
        frames_done++;
        start = chain;
        @(posedge clk); #1;
        start = 1'b0;
        if (chain) begin
            chk("chained_busy", 32'(busy), 32'd1);
        end else begin
            chk("idle_busy", 32'(busy), 32'd0);
            chk("done_once", 32'(done), 32'd0);
        end
    endtask

    initial begin
        logic [23:0] exp7 [7];
        int          idx;
        int          cyc;
        int          dones;
        logic [15:0] last_adr;

        res = 1'b1; start = 1'b0; start1 = 1'b0; pix_ready = 1'b0; ready1 = 1'b1;
        exp7 = '{BGC, BGC, FGC, FGC, FGC, BGC, BGC};
        for (int i = 0; i < 65536; i++) begin
            txt0[i] = 8'hC1;
            txt1[i] = 8'($urandom);
        end
        for (int i = 0; i < 1024; i++) rom0[i] = 8'($urandom);
        for (int i = 0; i < 512; i++)  rom1[i] = 8'($urandom);
        rom0[772] = 8'b0001_1100;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_txt_adr", 32'(txt_adr), 32'h400);
        chk("rst_crom_adr", 32'(crom_adr), 32'd0);
        chk("rst_pix_d", 32'(pix_d), 32'(BGC));
        chk("rst_pix_adr", 32'(pix_adr), 32'd0);
        chk("rst_lin_busy", 32'(busy1), 32'd0);
        res = 1'b0;

        // Uniform 'A' page, sink always ready.
        run_frame(100, -1, 1'b0, 1'b0);
        chk("first7_count", 32'(first7.size()), 32'd7);
        for (int i = 0; i < 7 && i < first7.size(); i++)
            chk("first7_pix", 32'(first7[i]), 32'(exp7[i]));

        // Random codes of all classes and random glyphs across flash phases.
        for (int i = 'h400; i < 'h800; i++) txt0[i] = 8'($urandom);
        for (int i = 0; i < 1024; i++) rom0[i] = 8'($urandom);
        run_frame(50, -1, 1'b1, 1'b0);
        run_frame(50, -1, 1'b0, 1'b1);
        run_frame(100, -1, 1'b0, 1'b0);
        run_frame(70, -1, 1'b0, 1'b0);

        // Abort mid-frame, then a clean restart.
        run_frame(100, 1000, 1'b0, 1'b0);
        run_frame(50, -1, 1'b0, 1'b0);

        // Linear map instance.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        idx = 0; cyc = 0; dones = 0; last_adr = '0;
        while (idx < TOT1 && cyc < 2000) begin
            if (done1) dones++;
            if (valid1) begin
                chk("lin_pix_adr", 32'(pix_adr1), 32'(idx));
                chk("lin_pix_d", 32'(pix_d1), 32'(m_pix(1'b1, idx, 1'b0)));
                chk("lin_txt_adr", 32'(txt_adr1), 32'(m_adr(idx, 3, 5, 2, 1'b0)));
                last_adr = pix_adr1;
            end
            start1 = (idx < TOT1 - 10) && ($urandom_range(3) == 0);
            @(posedge clk); #1;
            cyc++;
            if (valid1 === 1'b1 && cyc > 0) begin end
            if (last_adr == 16'(idx) && idx < TOT1 && pix_adr1 == 16'(idx + 1)) idx++;
        end
        start1 = 1'b0;
        chk("lin_count", 32'(idx), 32'(TOT1));
        chk("lin_last_adr", 32'(last_adr), 32'(TOT1 - 1));
        repeat (4) begin
            if (done1) dones++;
            @(posedge clk); #1;
        end
        chk("lin_done_once", 32'(dones), 32'd1);
        chk("lin_idle", 32'(busy1), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
